gf4_mul_2om_compress: RTL and testbench
=======================================

// Module: gf4_mul_2om_compress
// PURPOSE
// - Receiving end of the second-order masked GF(2^2) multiplier.
// - Captures the 9 per-coordinate component-function outputs (2 coordinates x 9 = 18 bits) in a register
//   stage, then XOR-compresses them into 3 output shares of 2 bits each, with a valid/ready handshake.
// - Sits between the CF array and the next stage of the masked GF(2^4)/AES S-box inverter.
// PARAMETERS
// - CNT_W  16  width of the saturating completed-operation counter
// PORTS
// - clk        in   1   clock, all state on rising edge
// - rst        in   1   asynchronous, active-high reset
// - cf_in      in   18  [8:0]=coordinate 0 CF outputs num 0..8; [17:9]=coordinate 1 CF outputs num 0..8
// - in_valid   in   1   cf_in valid
// - in_ready   out  1   stage A can accept this cycle
// - z1,z2,z3   out  2   output shares; bit1=coord 1, bit0=coord 0
// - out_valid  out  1   z1..z3 valid
// - out_ready  in   1   downstream accepts
// - op_count   out  CNT_W  completed transfers on output side, saturating
// BEHAVIOUR
// - Stage A: 18-bit register + valid bit; stage B: 6-bit share register + valid bit. No combinational
//   path from cf_in to z*: stage A is the mandatory glitch barrier before any compression XOR.
// - Compression (per coordinate c, reading stage A): z1[c]=cf[0]^cf[3]^cf[6]; z2[c]=cf[1]^cf[4]^cf[7];
//   z3[c]=cf[2]^cf[5]^cf[8]. Fresh-mask terms cancel only in z1^z2^z3; never XOR across groups.
// - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
// - in_ready = ~A_valid | (~B_valid | out_ready)  (A drains into B when B is empty or emptying).
// - A->B move when A_valid & (~B_valid | out_ready); A loads same cycle if in_valid.
// - Latency: 2 cycles cf_in -> z* with no stall; throughput 1 op/cycle.
// - Stall: out_ready=0 with B full -> B and A hold; A holds exactly its data (no overwrite, no drop).
// - Simultaneous in/out on full pipe: B<=compress(A), A<=cf_in, both valid stay 1.
// - Data registers not loaded when their valid would be 0 (no toggling with stale shares).
// - op_count: +1 per output transfer; stops at 2^CNT_W-1.
// - Reset (any time, incl. mid-stall): A_valid=B_valid=0, out_valid=0, in_ready=1, z1..z3=0,
//   A data=0, op_count=0. In-flight ops discarded; no partial output after release.
// - No FSM beyond the two valid bits: states EMPTY(00), ONE_A(10), ONE_B(01), FULL(11) per (A,B).
// STRUCTURE
// - Shared package: SHARES=3, CF_PER_COORD=9, group index constants (G1={0,3,6}, G2={1,4,7}, G3={2,5,8}).
// - One sub-module natural: gf4_share_xor3 (pure 3-input XOR per coordinate, instantiated 3x2).
// - Register stages in top level; keep compression strictly after stage A flops.
// TESTING
// - Reset then cf_in=18'h0_0049 (bits 0,3,6 of coord 0) valid 1 cycle, out_ready=1 -> 2 cycles later
//   out_valid=1, z1=2'b01 (3 ones -> 1), z2=z3=00; op_count=1.
// - Streaming 8 random ops back-to-back, out_ready=1 -> in_ready stays 1, outputs in order, 1/cycle,
//   z1^z2^z3 equals model XOR of all 9 CF bits per coordinate.
// - out_ready=0 for 5 cycles with 3 ops offered -> only 2 accepted, in_ready=0 while full, z* stable;
//   on release outputs appear in order, nothing lost or duplicated.
// - Full pipe, in_valid=1 and out_ready=1 same cycle -> both transfers occur, in_ready stays 1.
// - Assert rst mid-stall with FULL state -> out_valid=0, z*=0, op_count=0 immediately; no stale output later.
// - Force op_count near 2^CNT_W-1 (CNT_W=4 build) and run 20 ops -> op_count saturates at 15.

Source files
------------

// File: rtl/gf4_mul_2om_compress_pkg.sv
// Shared constants and types for the masked GF(2^2) multiplier compression stage.
package gf4_mul_2om_compress_pkg;

  localparam int SHARES       = 3;
  localparam int CF_PER_COORD = 9;
  localparam int COORDS       = 2;
  localparam int CF_W         = COORDS * CF_PER_COORD;
  localparam int GRP          = CF_PER_COORD / SHARES;  // CF terms folded into one share bit

  // CF indices folded into each output share. Mask terms only cancel across
  // the three shares combined, so a group must never mix with another group.
  localparam logic [GRP-1:0][3:0] G1 = {4'd6, 4'd3, 4'd0};
  localparam logic [GRP-1:0][3:0] G2 = {4'd7, 4'd4, 4'd1};
  localparam logic [GRP-1:0][3:0] G3 = {4'd8, 4'd5, 4'd2};
  localparam logic [SHARES-1:0][GRP-1:0][3:0] G_IDX = {G3, G2, G1};

  typedef logic [COORDS-1:0] share_t;  // bit1 = coord 1, bit0 = coord 0

  typedef struct packed {
    share_t z3;
    share_t z2;
    share_t z1;
  } shares_t;

endpackage

// File: rtl/gf4_share_xor3.sv
// One share bit for one coordinate: XOR of its three CF terms.
module gf4_share_xor3
  import gf4_mul_2om_compress_pkg::*;
(
  input  logic [GRP-1:0] a,
  output logic           y
);

  assign y = ^a;

endmodule

// File: rtl/gf4_mul_2om_compress.sv
// Two-stage register + XOR compression of 18 CF outputs into 3 two-bit shares.
// Stage A is the glitch barrier: every compression XOR reads only stage-A flops.
module gf4_mul_2om_compress
  import gf4_mul_2om_compress_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CF_W-1:0]  cf_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       z1,
  output logic [1:0]       z2,
  output logic [1:0]       z3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count
);

  logic                                    a_valid;
  logic [COORDS-1:0][CF_PER_COORD-1:0]     a_data;
  logic                                    b_valid;
  shares_t                                 b_q;
  logic [SHARES-1:0][COORDS-1:0]           comp;
  logic                                    a_move;
  logic                                    in_xfer;
  logic                                    out_xfer;

  // A drains into B whenever B is empty or being emptied this cycle.
  assign a_move   = a_valid & (~b_valid | out_ready);
  assign in_ready = ~a_valid | ~b_valid | out_ready;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = b_valid & out_ready;

  for (genvar c = 0; c < COORDS; c++) begin : g_coord
    for (genvar s = 0; s < SHARES; s++) begin : g_share
      gf4_share_xor3 u_xor (
        .a ({a_data[c][G_IDX[s][2]], a_data[c][G_IDX[s][1]], a_data[c][G_IDX[s][0]]}),
        .y (comp[s][c])
      );
    end
  end

  // Stage A: capture CF outputs; data only loads on an accepted input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_data  <= '0;
    end else if (in_xfer) begin
      a_valid <= 1'b1;
      a_data  <= cf_in;
    end else if (a_move) begin
      a_valid <= 1'b0;
    end
  end

  // Stage B: compressed shares; data only loads when A hands over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_q     <= '0;
    end else if (a_move) begin
      b_valid <= 1'b1;
      b_q     <= {comp[2], comp[1], comp[0]};
    end else if (out_xfer) begin
      b_valid <= 1'b0;
    end
  end

  // Saturating count of completed output transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_xfer && (op_count != '1)) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

  assign out_valid = b_valid;
  assign z1        = b_q.z1;
  assign z2        = b_q.z2;
  assign z3        = b_q.z3;

endmodule

// File: tb/tb_gf4_mul_2om_compress.sv
module tb_gf4_mul_2om_compress;

  typedef struct {
    logic [8:0] c1;
    logic [8:0] c0;
    logic [1:0] z1;
    logic [1:0] z2;
    logic [1:0] z3;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] cf_in = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [1:0]  z1, z2, z3;
  logic [15:0] op_count;
  logic        in_ready_s, out_valid_s;
  logic [1:0]  z1_s, z2_s, z3_s;
  logic [3:0]  op_count_s;

  vec_t tbl [12];
  vec_t exp_q [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   w;

  always #5 clk = ~clk;

  gf4_mul_2om_compress #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cf_in(cf_in), .in_valid(in_valid), .in_ready(in_ready),
    .z1(z1), .z2(z2), .z3(z3), .out_valid(out_valid), .out_ready(out_ready),
    .op_count(op_count)
  );

  // Narrow-counter build sharing the same stimulus, for saturation.
  gf4_mul_2om_compress #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .cf_in(cf_in), .in_valid(in_valid), .in_ready(in_ready_s),
    .z1(z1_s), .z2(z2_s), .z3(z3_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .op_count(op_count_s)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one vector starting at a negedge; push its expectation once accepted.
  task automatic send(int idx, int max_wait, output int waited);
    cf_in    = {tbl[idx].c1, tbl[idx].c0};
    in_valid = 1'b1;
    waited   = 0;
    #1;
    while (!in_ready && waited < max_wait) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("send_accept", 32'(in_ready), 1);
    if (in_ready) exp_q.push_back(tbl[idx]);
    @(negedge clk);
  endtask

  task automatic drain(int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk); #3;
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 0);
    @(negedge clk);
  endtask

  // Monitor: an output transfer at the coming posedge pops one expectation.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst && out_valid && out_ready) begin
        chk("out_has_expect", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("z_shares", 32'({z1, z2, z3}), 32'({e.z1, e.z2, e.z3}));
          chk("z_parity", 32'(z1 ^ z2 ^ z3), 32'({^e.c1, ^e.c0}));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            c1      c0      z1     z2     z3
    tbl[0]  = '{9'h000, 9'h049, 2'b01, 2'b00, 2'b00};
    tbl[1]  = '{9'h1FF, 9'h000, 2'b10, 2'b10, 2'b10};
    tbl[2]  = '{9'h001, 9'h002, 2'b10, 2'b01, 2'b00};
    tbl[3]  = '{9'h124, 9'h092, 2'b00, 2'b01, 2'b10};
    tbl[4]  = '{9'h009, 9'h100, 2'b00, 2'b00, 2'b01};
    tbl[5]  = '{9'h0F0, 9'h00F, 2'b10, 2'b01, 2'b11};
    tbl[6]  = '{9'h155, 9'h0AA, 2'b01, 2'b10, 2'b01};
    tbl[7]  = '{9'h038, 9'h1C0, 2'b11, 2'b11, 2'b11};
    tbl[8]  = '{9'h1FF, 9'h1FF, 2'b11, 2'b11, 2'b11};
    tbl[9]  = '{9'h000, 9'h000, 2'b00, 2'b00, 2'b00};
    tbl[10] = '{9'h040, 9'h010, 2'b10, 2'b01, 2'b00};
    tbl[11] = '{9'h100, 9'h008, 2'b01, 2'b00, 2'b10};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_z", 32'({z1, z2, z3}), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_op_count_sat", 32'(op_count_s), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single op: two-cycle latency
    send(0, 4, w);
    in_valid = 1'b0;
    #1;
    chk("lat_cycle1_out_valid", 32'(out_valid), 0);
    @(negedge clk); #1;
    chk("lat_cycle2_out_valid", 32'(out_valid), 1);
    chk("lat_z", 32'({z1, z2, z3}), 32'({2'b01, 2'b00, 2'b00}));
    @(negedge clk); #1;
    chk("op_count_1", 32'(op_count), 1);
    @(negedge clk);

    // Back-to-back streaming
    for (int i = 1; i <= 8; i++) begin
      send(i, 4, w);
      chk("stream_no_wait", 32'(w), 0);
    end
    in_valid = 1'b0;
    drain(10);

    // Stall: two accepted, third held off
    out_ready = 1'b0;
    send(9, 4, w);
    chk("stall_acc0_wait", 32'(w), 0);
    send(10, 4, w);
    chk("stall_acc1_wait", 32'(w), 0);
    cf_in    = {tbl[11].c1, tbl[11].c0};
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_z_hold", 32'({z1, z2, z3}), 32'({tbl[9].z1, tbl[9].z2, tbl[9].z3}));
      @(negedge clk);
    end

    // Full pipe with simultaneous input and output transfer
    out_ready = 1'b1;
    #1;
    chk("full_in_ready", 32'(in_ready), 1);
    exp_q.push_back(tbl[11]);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full_out_valid", 32'(out_valid), 1);
    chk("full_z_next", 32'({z1, z2, z3}), 32'({tbl[10].z1, tbl[10].z2, tbl[10].z3}));
    drain(10);
    chk("op_count_12", 32'(op_count), 12);
    chk("op_count_sat_12", 32'(op_count_s), 12);

    // Reset asserted while FULL and stalled
    out_ready = 1'b0;
    send(0, 4, w);
    send(1, 4, w);
    in_valid = 1'b0;
    @(negedge clk); #1;
    chk("pre_rst_full", 32'({out_valid, in_ready}), 32'(2'b10));
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_z", 32'({z1, z2, z3}), 0);
    chk("mid_rst_op_count", 32'(op_count), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("post_rst_no_out", 32'(out_valid), 0);
      @(negedge clk);
    end

    // 20 ops: narrow counter saturates at 15
    for (int i = 0; i < 20; i++) send(i % 12, 4, w);
    in_valid = 1'b0;
    drain(10);
    #1;
    chk("sat_count", 32'(op_count_s), 15);
    chk("wide_count", 32'(op_count), 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
